// File: rtl/expr_pkg.sv
// Shared constants and state encoding for the expression-processing path.
package expr_pkg;
   localparam logic [7:0] CH_0   = 8'h30;
   localparam logic [7:0] CH_9   = 8'h39;
   localparam logic [7:0] CH_ADD = 8'h2B;
   localparam logic [7:0] CH_MUL = 8'h2A;
   localparam logic [7:0] CH_EOL = 8'h0A;

   typedef enum logic [1:0] {S_NUM, S_OP, S_ERR} state_t;
endpackage

// File: rtl/char_class.sv
// Combinational ASCII classifier shared with the upstream recognizer.
module char_class
   import expr_pkg::*;
(
   input  logic [7:0] in,
   output logic       is_digit,
   output logic       is_add,
   output logic       is_mul,
   output logic       is_eol,
   output logic [3:0] dval
);
   assign is_digit = (in >= CH_0) && (in <= CH_9);
   assign is_add   = (in == CH_ADD);
   assign is_mul   = (in == CH_MUL);
   assign is_eol   = (in == CH_EOL);
   // Low nibble of '0'..'9' is the digit value.
   assign dval     = is_digit ? in[3:0] : 4'd0;
endmodule

// File: rtl/expr_eval.sv
// Evaluates digit (op digit)* expressions with '*' binding tighter than '+',
// terminated by line-feed.
module expr_eval
   import expr_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [7:0]   in,
   output logic [W-1:0] result,
   output logic         ok,
   output logic         err,
   output logic         done,
   output logic         done_ok,
   output logic [W-1:0] final_val
);
   logic       is_digit, is_add, is_mul, is_eol;
   logic [3:0] dval;

   char_class u_class (
      .in       (in),
      .is_digit (is_digit),
      .is_add   (is_add),
      .is_mul   (is_mul),
      .is_eol   (is_eol),
      .dval     (dval)
   );

   state_t       state, state_n;
   logic [W-1:0] sum, sum_n, term, term_n, fin_n;
   logic         mul_pend, mul_pend_n, err_n, done_n, done_ok_n;
   logic [W-1:0] dval_w;

   assign dval_w = {{(W-4){1'b0}}, dval};

   always_comb begin
      state_n    = state;
      sum_n      = sum;
      term_n     = term;
      mul_pend_n = mul_pend;
      err_n      = err;
      done_n     = 1'b0;
      done_ok_n  = done_ok;
      fin_n      = final_val;
      if (in_valid) begin
         if (is_eol) begin
            done_n     = 1'b1;
            done_ok_n  = (state == S_OP);
            fin_n      = sum + term;
            sum_n      = '0;
            term_n     = '0;
            mul_pend_n = 1'b0;
            err_n      = 1'b0;
            state_n    = S_NUM;
         end else begin
            case (state)
               S_NUM: begin
                  if (is_digit) begin
                     term_n     = mul_pend ? term * dval_w : dval_w;
                     mul_pend_n = 1'b0;
                     state_n    = S_OP;
                  end else begin
                     err_n   = 1'b1;
                     state_n = S_ERR;
                  end
               end
               S_OP: begin
                  if (is_add) begin
                     sum_n   = sum + term;
                     term_n  = '0;
                     state_n = S_NUM;
                  end else if (is_mul) begin
                     mul_pend_n = 1'b1;
                     state_n    = S_NUM;
                  end else begin
                     err_n   = 1'b1;
                     state_n = S_ERR;
                  end
               end
               default: ;  // S_ERR swallows everything until EOL
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= S_NUM;
         sum       <= '0;
         term      <= '0;
         mul_pend  <= 1'b0;
         result    <= '0;
         ok        <= 1'b0;
         err       <= 1'b0;
         done      <= 1'b0;
         done_ok   <= 1'b0;
         final_val <= '0;
      end else begin
         state     <= state_n;
         sum       <= sum_n;
         term      <= term_n;
         mul_pend  <= mul_pend_n;
         result    <= sum_n + term_n;
         ok        <= (state_n == S_OP) && !err_n;
         err       <= err_n;
         done      <= done_n;
         done_ok   <= done_ok_n;
         final_val <= fin_n;
      end
   end
endmodule

// File: tb/tb_expr_eval.sv
// Random and directed stimulus for expr_eval at W=16 and W=8, checked against
// a string-level reference evaluator.
module tb_expr_eval;
   logic        clk, clr, in_valid;
   logic [7:0]  in;
   logic [15:0] r16, f16;
   logic [7:0]  r8, f8;
   logic        ok16, err16, done16, dok16;
   logic        ok8, err8, done8, dok8;

   expr_eval #(.W(16)) u16 (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
      .result(r16), .ok(ok16), .err(err16), .done(done16),
      .done_ok(dok16), .final_val(f16)
   );
   expr_eval #(.W(8)) u8 (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
      .result(r8), .ok(ok8), .err(err8), .done(done8),
      .done_ok(dok8), .final_val(f8)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Model state: the text of the current line plus the latched termination info.
   logic [7:0]      line[$];
   logic            m_done, m_dok;
   longint unsigned m_fin16, m_fin8;

   function automatic bit is_dig(input logic [7:0] c);
      return c >= 8'h30 && c <= 8'h39;
   endfunction

   // Evaluate a line as text: find the longest syntactically valid prefix,
   // drop a trailing operator, then take the sum of the digit products.
   function automatic void eval_line(input logic [7:0] q[$], input longint unsigned mask,
                                     output logic e, output logic k, output longint unsigned v);
      int n = 0;
      longint unsigned total = 0, prod = 1;
      e = 0;
      for (int i = 0; i < q.size(); i++) begin
         if (i % 2 == 0 ? is_dig(q[i]) : (q[i] == 8'h2B || q[i] == 8'h2A)) n = i + 1;
         else begin
            e = 1;
            break;
         end
      end
      k = !e && (n % 2 == 1);
      if (n % 2 == 0 && n > 0) n--;
      for (int i = 0; i < n; i++) begin
         if (is_dig(q[i])) prod = (prod * longint'(q[i] - 8'h30)) & mask;
         else if (q[i] == 8'h2B) begin
            total = (total + prod) & mask;
            prod = 1;
         end
      end
      v = (n > 0) ? ((total + prod) & mask) : 0;
   endfunction

   task automatic model_reset();
      line.delete();
      m_done = 0; m_dok = 0; m_fin16 = 0; m_fin8 = 0;
   endtask

   task automatic send(input logic [7:0] c, input logic v);
      logic e, k;
      longint unsigned v16, v8;
      in = c;
      in_valid = v;
      @(posedge clk);
      #1;
      in_valid = 0;
      if (!v) m_done = 0;
      else if (c == 8'h0A) begin
         eval_line(line, 64'hFFFF, e, k, v16);
         eval_line(line, 64'hFF, e, k, v8);
         m_done = 1; m_dok = k; m_fin16 = v16; m_fin8 = v8;
         line.delete();
      end else begin
         line.push_back(c);
         m_done = 0;
      end
      eval_line(line, 64'hFFFF, e, k, v16);
      eval_line(line, 64'hFF, e, k, v8);
      chk("result16", 32'(r16), 32'(v16));
      chk("result8", 32'(r8), 32'(v8));
      chk("ok16", 32'(ok16), 32'(k));
      chk("ok8", 32'(ok8), 32'(k));
      chk("err16", 32'(err16), 32'(e));
      chk("err8", 32'(err8), 32'(e));
      chk("done16", 32'(done16), 32'(m_done));
      chk("done8", 32'(done8), 32'(m_done));
      chk("done_ok16", 32'(dok16), 32'(m_dok));
      chk("done_ok8", 32'(dok8), 32'(m_dok));
      chk("final16", 32'(f16), 32'(m_fin16));
      chk("final8", 32'(f8), 32'(m_fin8));
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         send(s[i], 1'b1);
         for (int g = 0; g < gap; g++) send(8'h00, 1'b0);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_result"}, 32'(r16) | 32'(r8), 0);
      chk({tag, "_flags"}, {ok16, err16, done16, dok16, ok8, err8, done8, dok8}, 0);
      chk({tag, "_final"}, 32'(f16) | 32'(f8), 0);
   endtask

   initial begin
      logic [7:0] c;
      logic [7:0] junk[4];
      int r;
      junk[0] = 8'h61; junk[1] = 8'h20; junk[2] = 8'h2F; junk[3] = 8'h3A;
      clr = 1; in_valid = 0; in = 0;
      model_reset();
      #3;
      chk_zero("reset");
      #9 clr = 0;

      send_str("2+3*4\n", 0);
      chk("prec_final", 32'(f16), 14);
      send_str("3*4*5", 0);
      send_str("\n", 0);
      send_str("2++3\n", 0);
      send_str("9*9*9*9", 0);
      chk("wrap8", 32'(r8), 161);
      chk("wrap16", 32'(r16), 6561);
      send_str("\n\n\n", 0);
      send_str("5*", 3);

      // Asynchronous clear between clock edges.
      clr = 1;
      #2;
      chk_zero("midclr");
      model_reset();
      #2 clr = 0;
      send_str("7\n", 0);
      chk("after_clr_final", 32'(f16), 7);
      send_str("+1\n", 0);
      send_str("1a\n", 0);
      send_str("9/\n0:\n", 1);

      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 8) c = 8'h0A;
         else if (r < 13) c = junk[$urandom_range(0, 3)];
         else if ((line.size() % 2 == 0) == (r < 90)) c = 8'h30 + 8'($urandom_range(0, 9));
         else c = ($urandom_range(0, 1) != 0) ? 8'h2B : 8'h2A;
         send(c, $urandom_range(0, 9) < 8);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Downstream of the character-stream recognizer in the expression-processing path.
- Consumes the same ASCII byte stream, one qualified byte per clock.
- Arithmetically evaluates expressions of the form digit (op digit)*, where op is '+' (0x2B) or '*' (0x2A) and '*' binds tighter than '+'.
- Reports the running value, a sticky syntax error, and a one-cycle completion pulse when a line-feed (0x0A) terminates the expression.

Parameters:
- W, 16, width of result and internal accumulators; all arithmetic is modulo 2^W.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies in; byte consumed on the clk edge where in_valid=1.
- in  input  8  ASCII character.
- result  output  W  value of expression so far, i.e. sum + term; registered.
- ok  output  1  1 when consumed prefix is a syntactically complete expression (ends in digit, no error).
- err  output  1  sticky syntax error for the current expression.
- done  output  1  one-cycle pulse on the cycle after a consumed line-feed.
- done_ok  output  1  valid with done; 1 iff the terminated expression was complete and error-free.
- final  output  W  value latched at termination; holds until next done or clr.

Behaviour:
- Reset (clr=1, async):
  - state=S_NUM; sum=0, term=0, mul_pend=0.
  - result=0, ok=0, err=0, done=0, done_ok=0, final=0.
  - Reset mid-expression discards all partial state.
- Character classes:
  - digit is 0x30..0x39, value d = in-0x30.
  - ADD is 0x2B; MUL is 0x2A; EOL is 0x0A; everything else is OTHER.
- in_valid=0: no state or accumulator change. done drops to 0; all other outputs hold.
- States and transitions (byte consumed):
  - S_NUM (expecting digit):
    - digit: term <= mul_pend ? term*d : d; mul_pend <= 0; go to S_OP.
    - ADD, MUL or OTHER: go to S_ERR, err <= 1.
  - S_OP (expecting operator):
    - ADD: sum <= sum+term; term <= 0; go to S_NUM.
    - MUL: mul_pend <= 1; go to S_NUM.
    - digit or OTHER: go to S_ERR, err <= 1. Multi-digit numbers are illegal.
  - S_ERR: absorbs everything except EOL; accumulators frozen.
  - EOL in any state:
    - done <= 1; done_ok <= (state==S_OP); final <= sum+term.
    - Then sum, term, mul_pend and err cleared; state <= S_NUM.
    - EOL as the first byte gives done=1, done_ok=0, final=0.
- Outputs:
  - All outputs are registered, with 1-cycle latency: they reflect the byte consumed at the previous edge.
  - result = next sum + next term, computed in the same cycle as the update.
  - ok=1 only when the next state is S_OP and err=0.
  - After EOL, result=0 and ok=0.
- Arithmetic:
  - Multiply uses W x 4 bits truncated to W.
  - Additions wrap modulo 2^W.
  - No overflow flag.
- Simultaneous events: clr dominates in_valid.
- Back-to-back EOLs each produce their own done pulse.

Decomposition:
- Shared package expr_pkg holds:
  - ASCII constants CH_0, CH_9, CH_ADD, CH_MUL, CH_EOL.
  - State enum {S_NUM, S_OP, S_ERR}.
- Sub-module char_class (combinational):
  - in -> is_digit, is_add, is_mul, is_eol, dval[3:0].
  - Reused by the upstream recognizer.
- expr_eval instantiates char_class and contains the FSM plus accumulators.

Test Plan:
- Precedence:
  - Stimulus: "2+3*4\n", contiguous in_valid.
  - Required: result sequence 2,2,5,5,14; ok 1,0,1,0,1; then done=1, done_ok=1, final=14, result=0.
- Product chain:
  - Stimulus: "3*4*5".
  - Required: result 3,3,12,12,60; err stays 0.
- Syntax error:
  - Stimulus: "2++3\n".
  - Required: err=1 from second '+' onward; ok=0 thereafter; done_ok=0, final=2; err cleared after done.
- Wrap-around (W=8):
  - Stimulus: "9*9*9*9".
  - Required: result 161 (6561 mod 256).
- Idle gaps and mid-stream reset:
  - Stimulus: "5*" with in_valid low for 3 cycles between bytes.
  - Required: outputs hold across the gaps.
  - Then assert clr asynchronously between edges: all outputs 0 immediately.
  - Then "7\n": final=7, done_ok=1.
- Leading operator and illegal character:
  - Stimulus: "+1\n" -> err=1 after the first byte, done_ok=0.
  - Stimulus: "1a\n" -> err=1 on 'a', done_ok=0, final=1.
